lfsr_gen: RTL and testbench

Parametrised linear-feedback shift register: it generalises the team's fixed 4-bit LFSR to any width, any tap mask and either Fibonacci or Galois form. It adds a clock enable, runtime seed load, all-zero lock-up recovery and a wrap pulse when the sequence returns to its seed. It sits in test-pattern and scrambler datapaths as the pseudo-random source.

---
 rtl/lfsr_pkg.sv | 34 +++
 rtl/lfsr_next.sv | 21 ++
 rtl/lfsr_gen.sv | 79 +++++++
 tb/tb_lfsr_gen.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared mode enum and width-generic next-state functions for lfsr_gen.
// Functions work on 32-bit containers; callers truncate to their own width.
package lfsr_pkg;

    typedef enum logic {
        LFSR_FIB = 1'b0,
        LFSR_GAL = 1'b1
    } lfsr_mode_e;

    function automatic logic [31:0] lfsr_width_mask(input int unsigned width);
        lfsr_width_mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    endfunction

    function automatic logic [31:0] lfsr_fib_next(input logic [31:0] s,
                                                  input logic [31:0] taps,
                                                  input int unsigned width);
        logic [31:0] mask;
        logic        fb;
        mask = lfsr_width_mask(width);
        fb   = ^(s & taps & mask);
        lfsr_fib_next = ((s << 1) | {31'b0, fb}) & mask;
    endfunction

    function automatic logic [31:0] lfsr_gal_next(input logic [31:0] s,
                                                  input logic [31:0] taps,
                                                  input int unsigned width);
        logic [31:0] mask;
        logic        msb;
        mask = lfsr_width_mask(width);
        msb  = s[5'(width - 1)];
        lfsr_gal_next = ((s << 1) & mask) ^ ({32{msb}} & taps & mask);
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Purely combinational LFSR next-state logic; form fixed at elaboration by MODE.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
    parameter lfsr_mode_e       MODE  = LFSR_FIB
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    generate
        if (MODE == LFSR_GAL) begin : g_gal
            always_comb nxt = WIDTH'(lfsr_gal_next(32'(cur), 32'(TAPS), WIDTH));
        end else begin : g_fib
            always_comb nxt = WIDTH'(lfsr_fib_next(32'(cur), 32'(TAPS), WIDTH));
        end
    endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR with clock enable, runtime seed load, all-zero recovery
// and a wrap pulse when the sequence returns to the active seed.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
    parameter lfsr_mode_e       MODE  = LFSR_FIB,
    parameter logic [WIDTH-1:0] SEED  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] out,
    output logic             bit_out,
    output logic             wrap,
    output logic             lockup
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("lfsr_gen: WIDTH must be in 2..32");
        end
        if (SEED == '0) begin : g_bad_seed
            $error("lfsr_gen: SEED must be non-zero");
        end
        if (MODE == LFSR_FIB && TAPS[WIDTH-1] == 1'b0) begin : g_bad_taps
            $error("lfsr_gen: Fibonacci TAPS must include bit WIDTH-1");
        end
    endgenerate

    logic [WIDTH-1:0] aseed;
    logic [WIDTH-1:0] nxt;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .MODE  (MODE)
    ) u_next (
        .cur (out),
        .nxt (nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out    <= SEED;
            aseed  <= SEED;
            wrap   <= 1'b0;
            lockup <= 1'b0;
        end else begin
            wrap   <= 1'b0;
            lockup <= 1'b0;
            if (load) begin
                // A zero seed would lock the register, so it is replaced by SEED.
                if (seed_in == '0) begin
                    out    <= SEED;
                    aseed  <= SEED;
                    lockup <= 1'b1;
                end else begin
                    out   <= seed_in;
                    aseed <= seed_in;
                end
            end else if (en) begin
                if (out == '0) begin
                    out    <= SEED;
                    lockup <= 1'b1;
                end else begin
                    out  <= nxt;
                    wrap <= (nxt == aseed);
                end
            end
        end
    end

    assign bit_out = out[WIDTH-1];

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed self-checking bench for lfsr_gen: Fibonacci, Galois, zero-lock shift
// register and 16-bit full-period instances, with hand-computed sequences.
module tb_lfsr_gen;
    import lfsr_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic en, load, en2;
    logic [3:0] seed_in;

    logic [3:0]  out0, out1, out3;
    logic [15:0] out2;
    logic bit0, bit1, bit2, bit3;
    logic wrap0, wrap1, wrap2, wrap3;
    logic lock0, lock1, lock2, lock3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lfsr_gen u0 (
        .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
        .out(out0), .bit_out(bit0), .wrap(wrap0), .lockup(lock0)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'b1001), .MODE(LFSR_GAL), .SEED(4'd1)) u1 (
        .clk(clk), .rst(rst), .en(en), .load(1'b0), .seed_in(4'h0),
        .out(out1), .bit_out(bit1), .wrap(wrap1), .lockup(lock1)
    );

    lfsr_gen #(.WIDTH(16), .TAPS(16'hB400), .MODE(LFSR_FIB), .SEED(16'd1)) u2 (
        .clk(clk), .rst(rst), .en(en2), .load(1'b0), .seed_in(16'h0000),
        .out(out2), .bit_out(bit2), .wrap(wrap2), .lockup(lock2)
    );

    // Galois with no taps degenerates to a shift register that reaches zero.
    lfsr_gen #(.WIDTH(4), .TAPS(4'b0000), .MODE(LFSR_GAL), .SEED(4'd1)) u3 (
        .clk(clk), .rst(rst), .en(en), .load(1'b0), .seed_in(4'h0),
        .out(out3), .bit_out(bit3), .wrap(wrap3), .lockup(lock3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] fib_tab [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                                 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    logic [3:0] gal_tab [15] = '{4'h2, 4'h4, 4'h8, 4'h9, 4'hB, 4'hF, 4'h7, 4'hE,
                                 4'h5, 4'hA, 4'hD, 4'h3, 4'h6, 4'hC, 4'h1};
    logic [3:0] fromA_tab [15] = '{4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1,
                                   4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA};
    logic [3:0] sh_tab [6]  = '{4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h2};
    logic       tog_en [8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] tog_out [8] = '{4'h2, 4'h2, 4'h2, 4'h4, 4'h9, 4'h9, 4'h3, 4'h3};

    int wraps2 = 0;
    int zeros2 = 0;
    int wrap_at = -1;

    initial begin
        rst = 1'b0;
        en = 1'b0;
        load = 1'b0;
        en2 = 1'b0;
        seed_in = 4'h0;
        repeat (2) step();

        chk("rst_out0",  32'(out0), 32'h1);
        chk("rst_bit0",  32'(bit0), 32'h0);
        chk("rst_wrap0", 32'(wrap0), 32'h0);
        chk("rst_lock0", 32'(lock0), 32'h0);
        chk("rst_out1",  32'(out1), 32'h1);
        chk("rst_out2",  32'(out2), 32'h1);

        rst = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            chk($sformatf("fib_out[%0d]", i), 32'(out0), 32'(fib_tab[i]));
            chk($sformatf("fib_wrap[%0d]", i), 32'(wrap0), (i == 14) ? 32'h1 : 32'h0);
            chk($sformatf("fib_bit[%0d]", i), 32'(bit0), 32'(fib_tab[i][3]));
            chk($sformatf("gal_out[%0d]", i), 32'(out1), 32'(gal_tab[i]));
            chk($sformatf("gal_wrap[%0d]", i), 32'(wrap1), (i == 14) ? 32'h1 : 32'h0);
            if (i < 6) begin
                chk($sformatf("sh_out[%0d]", i), 32'(out3), 32'(sh_tab[i]));
                chk($sformatf("sh_lock[%0d]", i), 32'(lock3), (i == 4) ? 32'h1 : 32'h0);
                chk($sformatf("sh_wrap[%0d]", i), 32'(wrap3), 32'h0);
            end
        end
        step();
        chk("fib_out16",  32'(out0), 32'h2);
        chk("fib_wrap16", 32'(wrap0), 32'h0);

        load = 1'b1;
        seed_in = 4'hA;
        step();
        chk("load_en_out",  32'(out0), 32'hA);
        chk("load_en_wrap", 32'(wrap0), 32'h0);
        load = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            chk($sformatf("seedA_out[%0d]", i), 32'(out0), 32'(fromA_tab[i]));
            chk($sformatf("seedA_wrap[%0d]", i), 32'(wrap0), (i == 14) ? 32'h1 : 32'h0);
        end

        en = 1'b0;
        load = 1'b1;
        seed_in = 4'h0;
        step();
        chk("zero_load_out",  32'(out0), 32'h1);
        chk("zero_load_lock", 32'(lock0), 32'h1);
        chk("zero_load_wrap", 32'(wrap0), 32'h0);
        load = 1'b0;
        step();
        chk("zero_load_lock_end", 32'(lock0), 32'h0);
        chk("zero_load_hold",     32'(out0), 32'h1);

        for (int i = 0; i < 8; i++) begin
            en = tog_en[i];
            step();
            chk($sformatf("tog_out[%0d]", i), 32'(out0), 32'(tog_out[i]));
            chk($sformatf("tog_wrap[%0d]", i), 32'(wrap0), 32'h0);
        end

        en = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_out",  32'(out0), 32'h1);
        chk("async_rst_bit",  32'(bit0), 32'h0);
        chk("async_rst_wrap", 32'(wrap0), 32'h0);
        chk("async_rst_lock", 32'(lock0), 32'h0);
        en = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("post_rst_hold", 32'(out0), 32'h1);

        en2 = 1'b1;
        for (int i = 1; i <= 65535; i++) begin
            step();
            if (wrap2) begin
                wraps2++;
                wrap_at = i;
            end
            if (out2 == 16'h0000) zeros2++;
        end
        en2 = 1'b0;
        chk("w16_wraps",   32'(wraps2), 32'd1);
        chk("w16_wrap_at", 32'(wrap_at), 32'd65535);
        chk("w16_zeros",   32'(zeros2), 32'd0);
        chk("w16_out",     32'(out2), 32'h1);
        chk("w16_lock",    32'(lock2), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
